npu_dispatch_ctrl: RTL and testbench

//   Sequences custom NPU instructions (OPCODE_NPU) from decode onto the shared NPU.

---
 rtl/npu_dispatch_ctrl_if.sv | 54 +++++
 rtl/npu_dispatch_ctrl.sv | 151 +++++++++++++++
 tb/tb_npu_dispatch_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : npu_dispatch_ctrl_if
//  Description : Decode-request, NPU-control and writeback bundle between the
//                pipeline, the NPU dispatch controller and the shared NPU.
//  Revision    : 1.0  initial release
// ============================================================================
interface npu_dispatch_ctrl_if #(
    parameter int XLEN = 64
);
    // decode request
    logic            req_valid;
    logic            req_ready;
    logic [6:0]      req_opcode;
    logic [6:0]      req_funct7;
    logic [4:0]      req_rd;
    logic [XLEN-1:0] req_rs1_val;
    logic [XLEN-1:0] req_rs2_val;
    // pipeline control
    logic            stall_o;
    logic            illegal_o;
    // NPU side
    logic            npu_start;
    logic [1:0]      npu_op;
    logic [XLEN-1:0] npu_src_addr;
    logic [XLEN-1:0] npu_cfg;
    logic            npu_busy;
    logic            npu_done;
    logic            npu_error;
    logic            npu_abort;
    // writeback
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    // controller view
    modport master (
        input  req_valid, req_opcode, req_funct7, req_rd, req_rs1_val, req_rs2_val,
        input  npu_busy, npu_done, npu_error,
        output req_ready, stall_o, illegal_o,
        output npu_start, npu_op, npu_src_addr, npu_cfg, npu_abort,
        output wb_valid, wb_rd, wb_data
    );

    // pipeline / NPU / environment view
    modport slave (
        output req_valid, req_opcode, req_funct7, req_rd, req_rs1_val, req_rs2_val,
        output npu_busy, npu_done, npu_error,
        input  req_ready, stall_o, illegal_o,
        input  npu_start, npu_op, npu_src_addr, npu_cfg, npu_abort,
        input  wb_valid, wb_rd, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/npu_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : npu_dispatch_ctrl
//  Description : Dispatches custom NPU instructions onto the shared NPU:
//                decodes funct7, issues one start pulse, stalls the front-end
//                until done or timeout, then writes a status/count word to rd.
//  Revision    : 1.0  initial release
// ============================================================================
module npu_dispatch_ctrl #(
    parameter int XLEN           = 64,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic            clk,
    input  wire logic            rst,
    npu_dispatch_ctrl_if.master  bus
);

    localparam logic [6:0]       c_OPCODE_NPU         = 7'b0001011;
    localparam logic [6:0]       c_FUNCT7_MATRIX_MUL  = 7'b0000001;
    localparam logic [6:0]       c_FUNCT7_CONVOLUTION = 7'b0000010;
    localparam logic [1:0]       c_NPU_OP_NONE        = 2'b00;
    localparam logic [1:0]       c_NPU_OP_MATMUL      = 2'b01;
    localparam logic [1:0]       c_NPU_OP_CONV        = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_MAX            = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_TIMEOUT            = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RUN   = 2'd2,
        S_WB    = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [XLEN-1:0]   cfg_q, cfg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              to_q, to_d;
    logic              illegal_q, illegal_d;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_start;
    logic              w_abort;

    // State and datapath registers; reset returns to IDLE with everything cleared
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= c_NPU_OP_NONE;
            rd_q      <= 5'd0;
            src_q     <= '0;
            cfg_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            src_q     <= src_d;
            cfg_q     <= cfg_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            to_q      <= to_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; the RUN counter always advances to n, so in WB it
    // already holds the count to report for both done and timeout exits
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        src_d     = src_q;
        cfg_d     = cfg_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        to_d      = to_q;
        illegal_d = 1'b0;
        w_start   = 1'b0;
        w_abort   = 1'b0;
        w_cnt_inc = (cnt_q == c_CNT_MAX) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && (bus.req_opcode == c_OPCODE_NPU)) begin
                    if ((bus.req_funct7 == c_FUNCT7_MATRIX_MUL) ||
                        (bus.req_funct7 == c_FUNCT7_CONVOLUTION)) begin
                        op_d    = (bus.req_funct7 == c_FUNCT7_MATRIX_MUL) ?
                                  c_NPU_OP_MATMUL : c_NPU_OP_CONV;
                        rd_d    = bus.req_rd;
                        src_d   = bus.req_rs1_val;
                        cfg_d   = bus.req_rs2_val;
                        state_d = S_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (!bus.npu_busy) begin
                    w_start = 1'b1;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = w_cnt_inc;
                if (bus.npu_done) begin
                    err_d   = bus.npu_error;
                    to_d    = 1'b0;
                    state_d = S_WB;
                end else if (w_cnt_inc == c_TIMEOUT) begin
                    w_abort = 1'b1;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are forced low while rst is asserted, whatever the current state
    assign bus.req_ready    = (state_q == S_IDLE) & ~rst;
    assign bus.stall_o      = (state_q != S_IDLE) & ~rst;
    assign bus.illegal_o    = illegal_q & ~rst;
    assign bus.npu_start    = w_start & ~rst;
    assign bus.npu_abort    = w_abort & ~rst;
    assign bus.npu_op       = (!rst && ((state_q == S_ISSUE) || (state_q == S_RUN))) ?
                              op_q : c_NPU_OP_NONE;
    assign bus.npu_src_addr = rst ? '0 : src_q;
    assign bus.npu_cfg      = rst ? '0 : cfg_q;
    assign bus.wb_valid     = (state_q == S_WB) & (rd_q != 5'd0) & ~rst;
    assign bus.wb_rd        = rst ? 5'd0 : rd_q;
    assign bus.wb_data      = rst ? '0 :
                              {err_q, to_q, {(XLEN-2-CNT_W){1'b0}}, cnt_q};

endmodule
`default_nettype wire

// File: tb/tb_npu_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_npu_dispatch_ctrl
//  Description : Self-checking bench for npu_dispatch_ctrl with a writeback
//                scoreboard (expected rd/data queued when a request is sent).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_npu_dispatch_ctrl;

    localparam logic [6:0] c_OPC_NPU = 7'b0001011;
    localparam logic [6:0] c_F_MM    = 7'b0000001;
    localparam logic [6:0] c_F_CONV  = 7'b0000010;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   n_start  = 0;
    int   n_abort  = 0;
    int   n_wb     = 0;
    wb_exp_t exp_q[$];

    npu_dispatch_ctrl_if #(.XLEN(64)) bus ();

    npu_dispatch_ctrl #(
        .XLEN           (64),
        .CNT_W          (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // event counters sampled mid-cycle
    always @(negedge clk) begin
        if (bus.npu_start) n_start++;
        if (bus.npu_abort) n_abort++;
        if (bus.wb_valid)  n_wb++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (got timeout, need finish)");
        $fatal(1, "watchdog");
    end

    // drive one request through an IDLE cycle; returns at #1 after the accept edge
    task automatic send(input logic [6:0] opc, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [63:0] a, input logic [63:0] b);
        @(posedge clk); #1;
        bus.req_valid   = 1'b1;
        bus.req_opcode  = opc;
        bus.req_funct7  = f7;
        bus.req_rd      = rd;
        bus.req_rs1_val = a;
        bus.req_rs2_val = b;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.stall_o} !== 2'b10)
            begin failures++; $display("FAIL send_idle: ready/stall got %b need 10", {bus.req_ready, bus.stall_o}); end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // from the ISSUE/start cycle: pulse done in RUN cycle k, check stall meanwhile
    task automatic run_done(input int k, input logic err);
        int bad = 0;
        for (int i = 1; i <= k; i++) begin
            @(posedge clk); #1;
            if (i == k) begin bus.npu_done = 1'b1; bus.npu_error = err; end
            @(negedge clk);
            if (bus.stall_o !== 1'b1 || bus.npu_abort !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        bus.npu_done  = 1'b0;
        bus.npu_error = 1'b0;
        checks++;
        if (bad != 0)
            begin failures++; $display("FAIL run_stall: bad RUN cycles got %0d need 0", bad); end
    endtask

    // wait for a writeback, compare against the scoreboard, then expect ready
    task automatic wait_wb(input string name);
        bit seen = 1'b0;
        wb_exp_t e;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (bus.wb_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++; $display("FAIL %s_wb: wb_valid got none need 1 pulse", name);
        end else if (exp_q.size() == 0) begin
            failures++; $display("FAIL %s_wb: unexpected wb rd=%0d data=%h need none", name, bus.wb_rd, bus.wb_data);
        end else begin
            e = exp_q.pop_front();
            if (bus.wb_rd !== e.rd || bus.wb_data !== e.data || bus.npu_op !== 2'b00) begin
                failures++;
                $display("FAIL %s_wb: rd=%0d data=%h op=%b need rd=%0d data=%h op=00",
                         name, bus.wb_rd, bus.wb_data, bus.npu_op, e.rd, e.data);
            end
        end
        if (seen) begin
            @(negedge clk);
            checks++;
            if ({bus.req_ready, bus.stall_o, bus.wb_valid} !== 3'b100)
                begin failures++; $display("FAIL %s_ready: ready/stall/wb got %b need 100", name, {bus.req_ready, bus.stall_o, bus.wb_valid}); end
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        wb_exp_t e;
        e.rd = rd; e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.stall_o, bus.npu_op, bus.npu_start, bus.wb_valid, bus.illegal_o, bus.npu_abort} !== 8'b0)
            begin failures++; $display("FAIL reset_outputs: got %b need 00000000",
                {bus.req_ready, bus.stall_o, bus.npu_op, bus.npu_start, bus.wb_valid, bus.illegal_o, bus.npu_abort}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.stall_o} !== 2'b10)
            begin failures++; $display("FAIL reset_release: ready/stall got %b need 10", {bus.req_ready, bus.stall_o}); end
    endtask

    task automatic test_matmul();
        int s0 = n_start;
        push(5'd5, 64'h0000_0000_0000_000A);
        send(c_OPC_NPU, c_F_MM, 5'd5, 64'h1000, 64'h0008_0008);
        @(negedge clk);
        checks++;
        if (bus.npu_start !== 1'b1 || bus.npu_op !== 2'b01 || bus.npu_src_addr !== 64'h1000 ||
            bus.npu_cfg !== 64'h0008_0008 || bus.stall_o !== 1'b1)
            begin failures++; $display("FAIL matmul_issue: start=%b op=%b src=%h cfg=%h stall=%b need 1 01 1000 80008 1",
                bus.npu_start, bus.npu_op, bus.npu_src_addr, bus.npu_cfg, bus.stall_o); end
        run_done(10, 1'b0);
        wait_wb("matmul");
        checks++;
        if (n_start - s0 != 1)
            begin failures++; $display("FAIL matmul_starts: got %0d need 1", n_start - s0); end
    endtask

    task automatic test_conv_busy();
        int early = 0;
        bus.npu_busy = 1'b1;
        push(5'd7, 64'h0000_0000_0000_0005);
        send(c_OPC_NPU, c_F_CONV, 5'd7, 64'h2000, 64'h33);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (bus.npu_start !== 1'b0 || bus.stall_o !== 1'b1 || bus.npu_op !== 2'b10) early++;
            @(posedge clk); #1;
            if (j == 2) bus.npu_busy = 1'b0;
        end
        checks++;
        if (early != 0)
            begin failures++; $display("FAIL conv_busy_hold: bad cycles got %0d need 0", early); end
        @(negedge clk);
        checks++;
        if (bus.npu_start !== 1'b1 || bus.npu_op !== 2'b10 || bus.npu_src_addr !== 64'h2000)
            begin failures++; $display("FAIL conv_start: start=%b op=%b src=%h need 1 10 2000",
                bus.npu_start, bus.npu_op, bus.npu_src_addr); end
        run_done(5, 1'b0);
        wait_wb("conv");
    endtask

    task automatic test_illegal();
        int s0 = n_start;
        int w0 = n_wb;
        send(c_OPC_NPU, 7'b0000011, 5'd4, 64'h10, 64'h20);
        @(negedge clk);
        checks++;
        if ({bus.illegal_o, bus.req_ready, bus.stall_o, bus.npu_start} !== 4'b1100)
            begin failures++; $display("FAIL illegal_pulse: ill/ready/stall/start got %b need 1100",
                {bus.illegal_o, bus.req_ready, bus.stall_o, bus.npu_start}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.illegal_o, bus.req_ready} !== 2'b01)
            begin failures++; $display("FAIL illegal_width: ill/ready got %b need 01", {bus.illegal_o, bus.req_ready}); end
        send(7'h33, c_F_MM, 5'd4, 64'h10, 64'h20);
        @(negedge clk);
        checks++;
        if ({bus.illegal_o, bus.req_ready, bus.stall_o} !== 3'b010)
            begin failures++; $display("FAIL non_npu: ill/ready/stall got %b need 010", {bus.illegal_o, bus.req_ready, bus.stall_o}); end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_start != s0 || n_wb != w0)
            begin failures++; $display("FAIL illegal_side: starts=%0d wbs=%0d need 0 0", n_start - s0, n_wb - w0); end
    endtask

    task automatic test_timeout();
        int a0 = n_abort;
        int at = 0;
        push(5'd9, 64'hC000_0000_0000_0010);
        send(c_OPC_NPU, c_F_MM, 5'd9, 64'h3000, 64'h1);
        @(negedge clk);
        for (int i = 1; i <= 30 && at == 0; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.npu_abort === 1'b1) at = i;
        end
        checks++;
        if (at != 16)
            begin failures++; $display("FAIL timeout_cycle: abort in RUN cycle %0d need 16", at); end
        @(posedge clk); #1;
        wait_wb("timeout");
        checks++;
        if (n_abort - a0 != 1)
            begin failures++; $display("FAIL timeout_aborts: got %0d need 1", n_abort - a0); end
    endtask

    task automatic test_error_rd0();
        send(c_OPC_NPU, c_F_CONV, 5'd0, 64'h4000, 64'h2);
        @(negedge clk);
        run_done(3, 1'b1);
        @(negedge clk);
        checks++;
        if ({bus.wb_valid, bus.stall_o} !== 2'b01)
            begin failures++; $display("FAIL rd0_wb: wb/stall got %b need 01", {bus.wb_valid, bus.stall_o}); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.stall_o, bus.npu_op} !== 4'b1000)
            begin failures++; $display("FAIL rd0_idle: ready/stall/op got %b need 1000", {bus.req_ready, bus.stall_o, bus.npu_op}); end
        push(5'd3, 64'h8000_0000_0000_0004);
        send(c_OPC_NPU, c_F_CONV, 5'd3, 64'h4000, 64'h2);
        @(negedge clk);
        run_done(4, 1'b1);
        wait_wb("err_rd3");
    endtask

    task automatic test_reset_mid_run();
        int w0 = n_wb;
        int a0 = n_abort;
        send(c_OPC_NPU, c_F_MM, 5'd6, 64'h5000, 64'h3);
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.stall_o, bus.req_ready, bus.wb_valid, bus.npu_abort, bus.npu_op} !== 6'b0)
            begin failures++; $display("FAIL midrst_hold: stall/ready/wb/abort/op got %b need 000000",
                {bus.stall_o, bus.req_ready, bus.wb_valid, bus.npu_abort, bus.npu_op}); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.stall_o} !== 2'b10)
            begin failures++; $display("FAIL midrst_idle: ready/stall got %b need 10", {bus.req_ready, bus.stall_o}); end
        @(posedge clk); #1;
        bus.npu_done = 1'b1;
        @(posedge clk); #1;
        bus.npu_done = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (n_wb != w0 || n_abort != a0 || bus.stall_o !== 1'b0)
            begin failures++; $display("FAIL midrst_quiet: wbs=%0d aborts=%0d stall=%b need 0 0 0",
                n_wb - w0, n_abort - a0, bus.stall_o); end
    endtask

    task automatic test_back_to_back();
        push(5'd12, 64'h0000_0000_0000_0002);
        send(c_OPC_NPU, c_F_MM, 5'd12, 64'h6000, 64'h4);
        @(negedge clk);
        checks++;
        if (bus.npu_start !== 1'b1 || bus.npu_op !== 2'b01)
            begin failures++; $display("FAIL b2b_start1: start/op got %b%b need 101", bus.npu_start, bus.npu_op); end
        run_done(2, 1'b0);
        wait_wb("b2b_1");
        push(5'd13, 64'h0000_0000_0000_0001);
        send(c_OPC_NPU, c_F_CONV, 5'd13, 64'h7000, 64'h5);
        @(negedge clk);
        checks++;
        if (bus.npu_start !== 1'b1 || bus.npu_op !== 2'b10 || bus.npu_cfg !== 64'h5)
            begin failures++; $display("FAIL b2b_start2: start=%b op=%b cfg=%h need 1 10 5",
                bus.npu_start, bus.npu_op, bus.npu_cfg); end
        run_done(1, 1'b0);
        wait_wb("b2b_2");
        checks++;
        if (exp_q.size() != 0)
            begin failures++; $display("FAIL scoreboard_left: entries got %0d need 0", exp_q.size()); end
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_opcode  = 7'd0;
        bus.req_funct7  = 7'd0;
        bus.req_rd      = 5'd0;
        bus.req_rs1_val = 64'd0;
        bus.req_rs2_val = 64'd0;
        bus.npu_busy    = 1'b0;
        bus.npu_done    = 1'b0;
        bus.npu_error   = 1'b0;
        test_reset();
        test_matmul();
        test_conv_busy();
        test_illegal();
        test_timeout();
        test_error_rd0();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
